pc_seq_unit: RTL and testbench

- Parametrised program-counter unit for the fetch stage. It replaces the fixed PC register plus the standalone PC+4 adder.
- Holds the PC and computes the sequential PC (pc_out + INC).
- Selects the next PC from three sources: sequential, PC-relative branch, absolute jump.
- Supports pipeline stall. A redirect that arrives during a stall is buffered and applied when the stall releases.
- Feeds instruction memory (pc_out) and the branch/link logic (adder1_out).

---
 rtl/pc_seq_unit.sv | 163 ++++++++++++++++
 tb/tb_pc_seq_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-stage program counter.
// Holds the PC, produces the sequential PC (pc_out + INC), and picks the next PC
// from sequential, PC-relative branch and absolute jump sources. A redirect seen
// while the pipeline is stalled is buffered and applied when the stall drops.
// Optional build macro: PC_ALIGN_CHECK_EN (misaligned targets trap to TRAP_VECTOR
// and pulse align_fault for one cycle).
module pc_seq_unit #(
    parameter int              WIDTH        = 32,
    parameter int              INC          = 4,
    parameter int              IMM_W        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [IMM_W-1:0] branch_imm,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] adder1_out,
    output logic             pc_valid,
    output logic             redirect_pending,
    output logic             align_fault
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   pend_target_q, pend_target_d;
    logic               pend_valid_q, pend_valid_d;
    logic               started_q;

    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   branch_tgt;
    logic               redirect;
    logic [WIDTH-1:0]   redir_tgt;
    logic               apply;
    logic [WIDTH-1:0]   apply_tgt;

`ifdef PC_ALIGN_CHECK_EN
    logic               align_fault_q, align_fault_d;
`endif

    // Sequential PC and branch target arithmetic (both wrap modulo 2^WIDTH)
    always_comb begin
        adder1_out = pc_q + INC_W;
        imm_ext    = {{(WIDTH-IMM_W){branch_imm[IMM_W-1]}}, branch_imm};
        branch_tgt = adder1_out + (imm_ext << 2);
        redirect   = jump | branch_taken;
        redir_tgt  = jump ? jump_target : branch_tgt;
    end

    // Next-state logic: PC selection, stall buffering and optional alignment trap
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        apply         = 1'b0;
        apply_tgt     = pc_q;
`ifdef PC_ALIGN_CHECK_EN
        align_fault_d = 1'b0;
`endif

        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        apply     = 1'b1;
                        apply_tgt = redir_tgt;
                    end else begin
                        pc_d = adder1_out;
                    end
                end else if (redirect) begin
                    pend_target_d = redir_tgt;
                    pend_valid_d  = 1'b1;
                    state_d       = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    // newest redirect overwrites the buffered one
                    if (redirect) begin
                        pend_target_d = redir_tgt;
                    end
                end else begin
                    // a live redirect on the release cycle beats the buffer
                    apply        = 1'b1;
                    apply_tgt    = redirect ? redir_tgt : pend_target_q;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d      = ST_RUN;
                pend_valid_d = 1'b0;
            end
        endcase

        // Targets are only checked when applied, so a buffered misaligned
        // redirect traps on the release cycle rather than at capture.
        if (apply) begin
`ifdef PC_ALIGN_CHECK_EN
            if ((apply_tgt % INC_W) != '0) begin
                pc_d          = TRAP_VECTOR;
                align_fault_d = 1'b1;
                pend_valid_d  = 1'b0;
                pend_target_d = '0;
                state_d       = ST_RUN;
            end else begin
                pc_d = apply_tgt;
            end
`else
            pc_d = apply_tgt;
`endif
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_VECTOR;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            started_q     <= 1'b1;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle alignment fault pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= align_fault_d;
        end
    end

    assign align_fault = align_fault_q;
`else
    assign align_fault = 1'b0;
`endif

    assign pc_out           = pc_q;
    assign pc_valid         = started_q & ~stall;
    assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed bench for pc_seq_unit with a scoreboard of expected
// post-edge PC / pending / fault values.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] adder1_out;
    logic        pc_valid;
    logic        redirect_pending;
    logic        align_fault;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        af;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_exp;
    logic        started_m;

    pc_seq_unit #(
        .WIDTH       (32),
        .INC         (4),
        .IMM_W       (16),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0080)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_imm      (branch_imm),
        .jump            (jump),
        .jump_target     (jump_target),
        .pc_out          (pc_out),
        .adder1_out      (adder1_out),
        .pc_valid        (pc_valid),
        .redirect_pending(redirect_pending),
        .align_fault     (align_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs before the
    // edge, then compare the registered outputs against the scoreboard.
    task automatic step(input string tag, input logic s, input logic b,
                        input logic [15:0] imm, input logic j, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic e_pend, input logic e_af);
        exp_t e;
        stall        = s;
        branch_taken = b;
        branch_imm   = imm;
        jump         = j;
        jump_target  = jt;
        sb.push_back('{pc: e_pc, pend: e_pend, af: e_af});
        #1;
        chk({tag, ".adder1"}, adder1_out, pc_exp + 32'd4);
        chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, started_m & ~s});
        @(posedge clk);
        #1;
        started_m = 1'b1;
        e = sb.pop_front();
        pc_exp = e.pc;
        chk({tag, ".pc"}, pc_out, e.pc);
        chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, e.pend});
        chk({tag, ".af"}, {31'd0, align_fault}, {31'd0, e.af});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = '0;
        jump         = 1'b0;
        jump_target  = '0;
        pc_exp       = 32'h0;
        started_m    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", pc_out, 32'h0);
        chk("rst.pend", {31'd0, redirect_pending}, 32'd0);
        chk("rst.valid", {31'd0, pc_valid}, 32'd0);
        chk("rst.af", {31'd0, align_fault}, 32'd0);
        rst_n = 1'b1;

        // sequential run after reset release
        step("seq0", 0, 0, 16'h0, 0, 32'h0, 32'h4, 0, 0);
        step("seq1", 0, 0, 16'h0, 0, 32'h0, 32'h8, 0, 0);
        step("seq2", 0, 0, 16'h0, 0, 32'h0, 32'hC, 0, 0);

        // wrap at the top of the address space
        step("wrapj", 0, 0, 16'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
        step("wrap", 0, 0, 16'h0, 0, 32'h0, 32'h0, 0, 0);

        // branch and priority
        step("j100", 0, 0, 16'h0, 1, 32'h100, 32'h100, 0, 0);
        step("brneg", 0, 1, 16'hFFFE, 0, 32'h0, 32'h0FC, 0, 0);
        step("j100b", 0, 0, 16'h0, 1, 32'h100, 32'h100, 0, 0);
        step("prio", 0, 1, 16'hFFFE, 1, 32'h400, 32'h400, 0, 0);

        // stall buffering: branch to 0x200 then jump to 0x300 while stalled
        step("st0", 1, 0, 16'h0, 0, 32'h0, 32'h400, 0, 0);
        step("st1", 1, 1, 16'hFF7F, 0, 32'h0, 32'h400, 1, 0);
        step("st2", 1, 0, 16'h0, 1, 32'h300, 32'h400, 1, 0);
        step("st3", 1, 0, 16'h0, 0, 32'h0, 32'h400, 1, 0);
        step("rel", 0, 0, 16'h0, 0, 32'h0, 32'h300, 0, 0);
        step("seq3", 0, 0, 16'h0, 0, 32'h0, 32'h304, 0, 0);

        // live redirect on the release cycle beats the buffer
        step("st4", 1, 0, 16'h0, 1, 32'h600, 32'h304, 1, 0);
        step("rellive", 0, 0, 16'h0, 1, 32'h500, 32'h500, 0, 0);

        // misaligned jump target
`ifdef PC_ALIGN_CHECK_EN
        step("mis", 0, 0, 16'h0, 1, 32'h102, 32'h80, 0, 1);
        step("mis1", 0, 0, 16'h0, 0, 32'h0, 32'h84, 0, 0);
`else
        step("mis", 0, 0, 16'h0, 1, 32'h102, 32'h102, 0, 0);
        step("mis1", 0, 0, 16'h0, 0, 32'h0, 32'h106, 0, 0);
`endif

        // asynchronous reset while a redirect is buffered
        step("st5", 1, 0, 16'h0, 1, 32'h700, pc_exp, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pc", pc_out, 32'h0);
        chk("arst.pend", {31'd0, redirect_pending}, 32'd0);
        chk("arst.valid", {31'd0, pc_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst.hold", pc_out, 32'h0);
        rst_n     = 1'b1;
        pc_exp    = 32'h0;
        started_m = 1'b0;
        step("post", 0, 0, 16'h0, 0, 32'h0, 32'h4, 0, 0);
        step("post1", 0, 0, 16'h0, 0, 32'h0, 32'h8, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
